// File: rtl/backward_arbiter_pkg.sv
// Shared crossbar arbitration types and width helpers.
//   arb_state_t : arbiter FSM state (idle / burst locked)
//   mst_idw()   : bits needed for a master index
//   slv_idw()   : bits needed for a slave index
package backward_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    function automatic int unsigned mst_idw(input int unsigned masters);
        return $clog2(masters);
    endfunction

    function automatic int unsigned slv_idw(input int unsigned slaves);
        return $clog2(slaves);
    endfunction

endpackage

// File: rtl/backward_arbiter_rr_pointer_picker.sv
// Combinational round-robin picker: returns the first set bit of req found by
// searching start_ptr, start_ptr+1, ... cyclically (wraps at width-1 -> 0, so
// width need not be a power of two).
//   req       : request vector
//   start_ptr : index with highest priority
//   grant     : selected index (start_ptr when nothing requests)
//   any_req   : at least one request present
module rr_pointer_picker #(
    parameter int unsigned width = 4
) (
    input  logic [width-1:0]         req,
    input  logic [$clog2(width)-1:0] start_ptr,
    output logic [$clog2(width)-1:0] grant,
    output logic                     any_req
);

    localparam int unsigned IW = $clog2(width);

    logic found;
    int unsigned idx;

    always_comb begin
        grant   = start_ptr;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < width; i++) begin
            // start_ptr < width and i < width, so one subtraction wraps
            idx = int'(start_ptr) + i;
            if (idx >= width) begin
                idx = idx - width;
            end
            if (!found && req[idx]) begin
                grant = IW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/backward_arbiter.sv
// Per-master response-path arbiter. Picks which slave response FIFO pushes into
// this master's response FIFO, round-robin among slaves whose head targets this
// master, and holds the grant for a whole burst until its last beat moves.
//   ACLK / ARESETn     : clock, synchronous active-low reset
//   slave_fifo_empty   : per-slave response FIFO empty
//   slave_master_dest  : destination master of each slave FIFO head
//   slave_last         : head entry is the final beat of its burst
//   master_fifo_full   : this master's response FIFO is full
//   grant_valid        : granted slave has a beat for us (not gated by full)
//   grant_slave_number : currently selected slave
//   slave_pop          : one-hot pop strobe to the granted slave
//   burst_locked       : a multi-beat burst holds the grant
module backward_arbiter
    import backward_arbiter_pkg::*;
#(
    parameter int unsigned masters            = 2,
    parameter int unsigned slaves             = 2,
    parameter int unsigned i_am_master_number = 0
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          slave_fifo_empty  [0:slaves-1],
    input  logic [mst_idw(masters)-1:0]   slave_master_dest [0:slaves-1],
    input  logic                          slave_last        [0:slaves-1],
    input  logic                          master_fifo_full,
    output logic                          grant_valid,
    output logic [slv_idw(slaves)-1:0]    grant_slave_number,
    output logic [slaves-1:0]             slave_pop,
    output logic                          burst_locked
);

    localparam int unsigned MST_IDW = mst_idw(masters);
    localparam int unsigned SLV_IDW = slv_idw(slaves);

    arb_state_t           state_q, state_d;
    logic [SLV_IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SLV_IDW-1:0]   locked_slave_q, locked_slave_d;

    logic [slaves-1:0]    req;
    logic [SLV_IDW-1:0]   rr_grant;
    logic                 rr_any;
    logic                 transfer;

    function automatic logic [SLV_IDW-1:0] next_ptr(input logic [SLV_IDW-1:0] g);
        return (g == SLV_IDW'(slaves - 1)) ? '0 : g + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < slaves; i++) begin
            req[i] = ~slave_fifo_empty[i] &
                     (slave_master_dest[i] == MST_IDW'(i_am_master_number));
        end
    end

    rr_pointer_picker #(
        .width (slaves)
    ) u_picker (
        .req       (req),
        .start_ptr (rr_ptr_q),
        .grant     (rr_grant),
        .any_req   (rr_any)
    );

    // Outputs: zero-cycle path from request to grant.
    always_comb begin
        grant_valid        = 1'b0;
        grant_slave_number = rr_ptr_q;
        slave_pop          = '0;
        burst_locked       = (state_q == ARB_LOCKED);
        if (state_q == ARB_LOCKED) begin
            // Other requesters are ignored; an absent head is a bubble.
            grant_slave_number = locked_slave_q;
            grant_valid        = req[locked_slave_q];
        end else begin
            grant_slave_number = rr_grant;
            grant_valid        = rr_any;
        end
        transfer = grant_valid & ~master_fifo_full;
        if (transfer) begin
            slave_pop[grant_slave_number] = 1'b1;
        end
    end

    // Next state: nothing moves without a transfer, so full never advances priority.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        locked_slave_d = locked_slave_q;
        if (transfer) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (slave_last[grant_slave_number]) begin
                        rr_ptr_d = next_ptr(grant_slave_number);
                    end else begin
                        state_d        = ARB_LOCKED;
                        locked_slave_d = grant_slave_number;
                    end
                end
                ARB_LOCKED: begin
                    if (slave_last[locked_slave_q]) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = next_ptr(locked_slave_q);
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q        <= ARB_IDLE;
            rr_ptr_q       <= '0;
            locked_slave_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            locked_slave_q <= locked_slave_d;
        end
    end

endmodule

// File: tb/tb_backward_arbiter.sv
// Directed bench for backward_arbiter with masters=2, slaves=4, serving master 1.
// Observed vector layout: {grant_valid, grant_slave_number[1:0], slave_pop[3:0], burst_locked}.
module tb_backward_arbiter;

    logic       ACLK;
    logic       ARESETn;
    logic       slave_fifo_empty  [0:3];
    logic [0:0] slave_master_dest [0:3];
    logic       slave_last        [0:3];
    logic       master_fifo_full;
    logic       grant_valid;
    logic [1:0] grant_slave_number;
    logic [3:0] slave_pop;
    logic       burst_locked;

    int passed;
    int total;

    backward_arbiter #(
        .masters            (2),
        .slaves             (4),
        .i_am_master_number (1)
    ) dut (
        .ACLK               (ACLK),
        .ARESETn            (ARESETn),
        .slave_fifo_empty   (slave_fifo_empty),
        .slave_master_dest  (slave_master_dest),
        .slave_last         (slave_last),
        .master_fifo_full   (master_fifo_full),
        .grant_valid        (grant_valid),
        .grant_slave_number (grant_slave_number),
        .slave_pop          (slave_pop),
        .burst_locked       (burst_locked)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [7:0] obs();
        return {grant_valid, grant_slave_number, slave_pop, burst_locked};
    endfunction

    // Expected vector for a granted slave s.
    function automatic logic [7:0] granted(input int s, input logic pop, input logic lock);
        logic [3:0] p;
        p = pop ? 4'(1 << s) : 4'b0000;
        return {1'b1, 2'(s), p, lock};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_slave(input int s, input logic present, input logic d, input logic l);
        slave_fifo_empty[s]  = ~present;
        slave_master_dest[s] = d;
        slave_last[s]        = l;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) set_slave(i, 1'b0, 1'b0, 1'b1);
        master_fifo_full = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_all();
        do_reset();
        total++;
        if (obs() !== 8'b0_00_0000_0) begin
            $display("FAIL reset_idle: got %b want %b", obs(), 8'b0_00_0000_0);
        end else passed++;
        // Head targeting master 0 must be ignored.
        set_slave(0, 1'b1, 1'b0, 1'b1);
        #1;
        total++;
        if (obs() !== 8'b0_00_0000_0) begin
            $display("FAIL dest_filter: got %b want %b", obs(), 8'b0_00_0000_0);
        end else passed++;
        clear_all();
    endtask

    task automatic test_single();
        set_slave(2, 1'b1, 1'b1, 1'b1);
        #1;
        total++;
        if (obs() !== granted(2, 1'b1, 1'b0)) begin
            $display("FAIL single_grant: got %b want %b", obs(), granted(2, 1'b1, 1'b0));
        end else passed++;
        tick();
        clear_all();
        // With no request the reported slave is rr_ptr, now 3.
        total++;
        if (obs() !== 8'b0_11_0000_0) begin
            $display("FAIL single_rr_ptr: got %b want %b", obs(), 8'b0_11_0000_0);
        end else passed++;
    endtask

    task automatic test_round_robin();
        int order [6];
        order = '{0, 1, 3, 0, 1, 3};
        clear_all();
        do_reset();
        set_slave(0, 1'b1, 1'b1, 1'b1);
        set_slave(1, 1'b1, 1'b1, 1'b1);
        set_slave(3, 1'b1, 1'b1, 1'b1);
        #1;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (obs() !== granted(order[k], 1'b1, 1'b0)) begin
                $display("FAIL rr_order[%0d]: got %b want %b", k, obs(),
                         granted(order[k], 1'b1, 1'b0));
            end else passed++;
            tick();
        end
        clear_all();
    endtask

    task automatic test_burst();
        // rr_ptr is 0: a single beat from slave 0 moves it to 1.
        set_slave(0, 1'b1, 1'b1, 1'b1);
        #1;
        tick();
        set_slave(1, 1'b1, 1'b1, 1'b0);
        #1;
        for (int b = 1; b <= 4; b++) begin
            set_slave(1, 1'b1, 1'b1, (b == 4));
            #1;
            total++;
            if (obs() !== granted(1, 1'b1, (b != 1))) begin
                $display("FAIL burst_beat%0d: got %b want %b", b, obs(),
                         granted(1, 1'b1, (b != 1)));
            end else passed++;
            tick();
        end
        set_slave(1, 1'b0, 1'b1, 1'b1);
        #1;
        total++;
        if (obs() !== granted(0, 1'b1, 1'b0)) begin
            $display("FAIL burst_then_s0: got %b want %b", obs(), granted(0, 1'b1, 1'b0));
        end else passed++;
        tick();
        clear_all();
    endtask

    task automatic test_bubble();
        // rr_ptr is 1: start a burst on slave 1.
        set_slave(1, 1'b1, 1'b1, 1'b0);
        #1;
        tick();
        set_slave(2, 1'b1, 1'b1, 1'b1);
        set_slave(1, 1'b0, 1'b1, 1'b0);
        #1;
        for (int c = 0; c < 2; c++) begin
            // Second bubble cycle: head present but aimed at master 0.
            if (c == 1) set_slave(1, 1'b1, 1'b0, 1'b0);
            #1;
            total++;
            if (obs() !== 8'b0_01_0000_1) begin
                $display("FAIL bubble[%0d]: got %b want %b", c, obs(), 8'b0_01_0000_1);
            end else passed++;
            tick();
        end
        set_slave(1, 1'b1, 1'b1, 1'b1);
        #1;
        total++;
        if (obs() !== granted(1, 1'b1, 1'b1)) begin
            $display("FAIL bubble_resume: got %b want %b", obs(), granted(1, 1'b1, 1'b1));
        end else passed++;
        tick();
        set_slave(1, 1'b0, 1'b1, 1'b1);
        #1;
        total++;
        if (obs() !== granted(2, 1'b1, 1'b0)) begin
            $display("FAIL bubble_then_s2: got %b want %b", obs(), granted(2, 1'b1, 1'b0));
        end else passed++;
        tick();
        clear_all();
    endtask

    task automatic test_full();
        // rr_ptr is 3; slave 0 also requests to show priority does not move.
        set_slave(3, 1'b1, 1'b1, 1'b1);
        set_slave(0, 1'b1, 1'b1, 1'b1);
        master_fifo_full = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (obs() !== granted(3, 1'b0, 1'b0)) begin
                $display("FAIL full_hold[%0d]: got %b want %b", c, obs(),
                         granted(3, 1'b0, 1'b0));
            end else passed++;
            tick();
        end
        master_fifo_full = 1'b0;
        #1;
        total++;
        if (obs() !== granted(3, 1'b1, 1'b0)) begin
            $display("FAIL full_release: got %b want %b", obs(), granted(3, 1'b1, 1'b0));
        end else passed++;
        tick();
        set_slave(3, 1'b0, 1'b1, 1'b1);
        #1;
        total++;
        if (obs() !== granted(0, 1'b1, 1'b0)) begin
            $display("FAIL full_then_s0: got %b want %b", obs(), granted(0, 1'b1, 1'b0));
        end else passed++;
        clear_all();
    endtask

    task automatic test_reset_mid_burst();
        // rr_ptr is 0: lock onto a burst from slave 2.
        set_slave(2, 1'b1, 1'b1, 1'b0);
        #1;
        tick();
        total++;
        if (obs() !== granted(2, 1'b1, 1'b1)) begin
            $display("FAIL lock_s2: got %b want %b", obs(), granted(2, 1'b1, 1'b1));
        end else passed++;
        set_slave(0, 1'b1, 1'b1, 1'b1);
        do_reset();
        total++;
        if (obs() !== granted(0, 1'b1, 1'b0)) begin
            $display("FAIL reset_mid_burst: got %b want %b", obs(), granted(0, 1'b1, 1'b0));
        end else passed++;
        clear_all();
        total++;
        if (obs() !== 8'b0_00_0000_0) begin
            $display("FAIL reset_rr_ptr: got %b want %b", obs(), 8'b0_00_0000_0);
        end else passed++;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        ARESETn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slave_fifo_empty[i]  = 1'b1;
            slave_master_dest[i] = 1'b0;
            slave_last[i]        = 1'b1;
        end
        master_fifo_full = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_bubble();
        test_full();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
